// File: rtl/inst_queue_ctrl.sv
// Instruction queue between fetcher and decoder: circular FIFO with registered issue port.
// Define INSTQ_BYPASS_EN to let a fetch into an empty queue issue directly at the same edge.
module inst_queue_ctrl #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetchValid,
  input  logic [31:0]       fetchPC,
  input  logic [31:0]       fetchInst,
  output logic              qFull,
  input  logic              dispStall,
  input  logic              flush,
  output logic              DecEn,
  output logic [31:0]       instPC,
  output logic [31:0]       inst,
  output logic [ADDR_W:0]   count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
  logic              dec_en_q, dec_en_d;
  entry_t            out_q, out_d;
  logic              empty, full, push, pop, byp;

  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
            (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
`ifdef INSTQ_BYPASS_EN
    byp   = empty && fetchValid && !dispStall && !flush;
`else
    byp   = 1'b0;
`endif
    // A bypassed fetch goes straight to the output and never occupies a slot.
    push  = fetchValid && !full && !flush && !byp;
    pop   = !empty && !dispStall && !flush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dec_en_d = 1'b0;
    out_d    = out_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        dec_en_d = 1'b1;
        out_d    = mem[rd_ptr_q[ADDR_W-1:0]];
      end else if (byp) begin
        dec_en_d = 1'b1;
        out_d    = '{pc: fetchPC, ins: fetchInst};
      end
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[ADDR_W-1:0]] <= '{pc: fetchPC, ins: fetchInst};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dec_en_q <= 1'b0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dec_en_q <= dec_en_d;
      out_q    <= out_d;
    end
  end

  assign qFull  = (count_q == (ADDR_W+1)'(DEPTH));
  assign count  = count_q;
  assign DecEn  = dec_en_q;
  assign instPC = out_q.pc;
  assign inst   = out_q.ins;

endmodule

// File: tb/tb_inst_queue_ctrl.sv
// Self-checking bench for inst_queue_ctrl: queue-based reference model plus directed literal checks.
module tb_inst_queue_ctrl;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              fetchValid, dispStall, flush;
  logic [31:0]       fetchPC, fetchInst;
  logic              qFull, DecEn;
  logic [31:0]       instPC, inst;
  logic [ADDR_W:0]   count;

  int total = 0;
  int bad   = 0;

  inst_queue_ctrl #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .fetchValid(fetchValid), .fetchPC(fetchPC),
    .fetchInst(fetchInst), .qFull(qFull), .dispStall(dispStall), .flush(flush),
    .DecEn(DecEn), .instPC(instPC), .inst(inst), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue, the issue port three variables.
  logic [31:0] pcq[$];
  logic [31:0] iq[$];
  logic        m_en = 1'b0;
  logic [31:0] m_pc = '0, m_in = '0;
  bit          m_full, m_byp;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcq.delete(); iq.delete();
      m_en = 1'b0; m_pc = '0; m_in = '0;
    end else if (flush) begin
      pcq.delete(); iq.delete();
      m_en = 1'b0;
    end else begin
      m_full = (pcq.size() == DEPTH);
`ifdef INSTQ_BYPASS_EN
      m_byp = (pcq.size() == 0) && fetchValid && !dispStall;
`else
      m_byp = 1'b0;
`endif
      if (m_byp) begin
        m_en = 1'b1; m_pc = fetchPC; m_in = fetchInst;
      end else begin
        if (pcq.size() > 0 && !dispStall) begin
          m_en = 1'b1; m_pc = pcq.pop_front(); m_in = iq.pop_front();
        end else
          m_en = 1'b0;
        if (fetchValid && !m_full) begin
          pcq.push_back(fetchPC); iq.push_back(fetchInst);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_DecEn", DecEn, m_en);
    chk("m_instPC", instPC, m_pc);
    chk("m_inst", inst, m_in);
    chk("m_count", count, pcq.size());
    chk("m_qFull", qFull, pcq.size() == DEPTH);
  end

  // Inputs change 2 time units after the falling edge, after the compare has sampled.
  task automatic cyc(input logic fv, input logic [31:0] pc, input logic [31:0] ins,
                     input logic st, input logic fl);
    fetchValid = fv; fetchPC = pc; fetchInst = ins; dispStall = st; flush = fl;
    @(posedge clk); @(negedge clk); #2;
  endtask

  initial begin
    bit found;
    logic [31:0] npc;
    rst = 1'b0;
    fetchValid = 1'b0; fetchPC = '0; fetchInst = '0; dispStall = 1'b0; flush = 1'b0;
    @(negedge clk); #2;

    cyc(1, 32'h44, 32'h55, 0, 0);
    cyc(1, 32'h44, 32'h55, 0, 0);
    chk("rst_DecEn", DecEn, 0);
    chk("rst_count", count, 0);
    chk("rst_qFull", qFull, 0);
    chk("rst_inst", inst, 0);
    rst = 1'b1;

    // Single issue
    cyc(1, 32'h100, 32'h00500093, 0, 0);
`ifdef INSTQ_BYPASS_EN
    chk("one_e1_DecEn", DecEn, 1);
    chk("one_e1_pc", instPC, 32'h100);
    chk("one_e1_inst", inst, 32'h00500093);
`else
    chk("one_e1_DecEn", DecEn, 0);
    chk("one_e1_count", count, 1);
`endif
    cyc(0, 0, 0, 0, 0);
`ifdef INSTQ_BYPASS_EN
    chk("one_e2_DecEn", DecEn, 0);
`else
    chk("one_e2_DecEn", DecEn, 1);
    chk("one_e2_pc", instPC, 32'h100);
    chk("one_e2_inst", inst, 32'h00500093);
`endif
    cyc(0, 0, 0, 0, 0);
    chk("one_e3_DecEn", DecEn, 0);

    // Fill to full under stall; the 9th fetch is dropped
    for (int i = 0; i < 9; i++) begin
      cyc(1, 32'(i * 4), 32'h13 | 32'(i << 20), 1, 0);
      if (i == 7) begin
        chk("fill_count8", count, 8);
        chk("fill_qFull", qFull, 1);
      end
    end
    chk("fill_count9", count, 8);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 0, 0);
      chk("drain_DecEn", DecEn, 1);
      chk("drain_pc", instPC, 32'(i * 4));
    end
    cyc(0, 0, 0, 0, 0);
    chk("drain_done_DecEn", DecEn, 0);
    chk("drain_done_count", count, 0);

    // Flush with a concurrent fetch
    for (int i = 0; i < 5; i++) cyc(1, 32'h40 + 32'(i * 4), 32'(i), 1, 0);
    chk("pre_flush_count", count, 5);
    cyc(1, 32'h200, 32'hdead, 0, 1);
    chk("flush_count", count, 0);
    chk("flush_DecEn", DecEn, 0);
    cyc(1, 32'h300, 32'hbeef, 0, 0);
    found = 0;
    for (int k = 0; k < 4; k++) begin
      if (DecEn) begin found = 1; break; end
      cyc(0, 0, 0, 0, 0);
    end
    chk("post_flush_seen", found, 1);
    chk("post_flush_pc", instPC, 32'h300);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);

    // Steady push+pop at occupancy 3
    for (int i = 0; i < 3; i++) cyc(1, 32'h1000 + 32'(i * 4), 32'(i), 1, 0);
    chk("steady_pre_count", count, 3);
    for (int k = 0; k < 10; k++) begin
      cyc(1, 32'h1000 + 32'((k + 3) * 4), 32'(k + 3), 0, 0);
      chk("steady_count", count, 3);
      chk("steady_DecEn", DecEn, 1);
      chk("steady_pc", instPC, 32'h1000 + 32'(k * 4));
    end
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 0, 0);

    // Randomized traffic, including rare flushes and mid-run resets
    npc = 32'h8000;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        rst = 1'b0;
        cyc($urandom_range(0, 1) == 1, npc, $urandom, 0, 0);
        rst = 1'b1;
      end
      cyc($urandom_range(0, 9) < 7, npc, $urandom,
          $urandom_range(0, 9) < 3, $urandom_range(0, 49) == 0);
      npc = npc + 4;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_queue_ctrl.md
Name: inst_queue_ctrl

Overview:
- Instruction queue and issue controller between the fetcher and the decoder.
- Buffers fetched instruction/PC pairs in a circular FIFO.
- Back-pressures the fetcher when full and drives the decoder's DecEn/instPC/inst one entry per cycle unless the dispatcher stalls.
- Flush (branch/jump redirect) discards all buffered and in-flight entries.

Parameters:
- DEPTH, 8, FIFO entries; power of two, ≥2.
- ADDR_W, 3, log2(DEPTH); pointers are ADDR_W+1 bits (extra wrap bit).

Ports:
- clk  in  1  system clock, posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- fetchValid  in  1  fetcher presents a valid instruction this cycle.
- fetchPC  in  32  PC of the fetched instruction.
- fetchInst  in  32  fetched instruction word.
- qFull  out  1  combinational; count==DEPTH; fetcher must hold while 1.
- dispStall  in  1  dispatcher/RS cannot accept; no issue this cycle.
- flush  in  1  redirect; empty queue, kill output.
- DecEn  out  1  registered; decoder consumes instPC/inst at next posedge.
- instPC  out  32  registered PC to decoder.
- inst  out  32  registered instruction to decoder.
- count  out  ADDR_W+1  registered occupancy, 0..DEPTH.

Behaviour:
- Reset (rst=0, async): wrPtr=rdPtr=0, count=0, DecEn=0, instPC=0, inst=0; qFull=0 follows from count. Reset mid-operation drops all entries immediately.
- empty = (wrPtr==rdPtr); full = (wrPtr[ADDR_W]!=rdPtr[ADDR_W]) && (wrPtr[ADDR_W-1:0]==rdPtr[ADDR_W-1:0]).
- push = fetchValid && !full && !flush: write {fetchPC,fetchInst} at wrPtr, wrPtr+1 (wraps naturally mod 2*DEPTH).
- pop = !empty && !dispStall && !flush: instPC/inst <= entry at rdPtr, DecEn<=1, rdPtr+1.
- No pop: DecEn<=0; instPC/inst hold last value.
- Push while full is ignored, even if a pop occurs the same cycle; the fetcher must re-present.
- Simultaneous push+pop (not full, not empty): count unchanged; both pointers advance.
- Pop reads the pre-write entry; a write to the same slot the same cycle cannot occur because that requires full.
- flush=1 (priority over everything): next edge wrPtr=rdPtr=0, count=0, DecEn=0; the fetch input that cycle is dropped.
- flush while dispStall: same result.
- count updates: +1 push only, −1 pop only, unchanged otherwise, 0 on flush.
- Latency without bypass: instruction pushed at edge N appears with DecEn=1 after edge N+1 (if not stalled).
- Decoder adds one more register stage.
- No combinational path from fetchValid to DecEn.

Optional Feature:
- INSTQ_BYPASS_EN
- Defined: when empty && fetchValid && !dispStall && !flush, the fetched pair loads the output registers directly at edge N with DecEn=1. It is not written to the FIFO; pointers and count are unchanged. Latency is 1 edge.
- Undefined: always push-then-pop; latency is 2 edges.
- Ordering is preserved in both builds, since bypass occurs only when empty.

Test Plan:
- Reset: hold rst=0 for 2 cycles with fetchValid=1 -> DecEn=0, count=0, qFull=0, inst=0. Release -> first push at next edge.
- Single issue: fetchPC=0x100, fetchInst=0x00500093 for one cycle.
  - No bypass: DecEn=1, instPC=0x100, inst=0x00500093 after 2nd edge, DecEn=0 the following cycle.
  - Bypass: same values after the 1st edge.
- Fill/full: dispStall=1, push 9 instructions PC 0x0..0x20 -> count=8 and qFull=1 after 8th; 9th (0x20) not stored. Release stall -> issues 0x0..0x1C in order, DecEn continuous 8 cycles.
- Wrap: push 6, pop 6, push 6, pop 6 with interleaved stalls -> PCs out in exact order, count back to 0, no duplicate or lost entry.
- Flush: 5 entries queued, flush=1 with fetchValid=1 PC 0x200 -> next cycle count=0, DecEn=0, 0x200 absent. A following push of 0x300 is the next issued.
- Simultaneous push/pop at count=3 -> count stays 3 across 10 cycles of continuous fetch and no stall; output PC sequence strictly increasing by 4.
